// File: rtl/hapara_icap_readback_if.sv
// Bus bundle for hapara_icap_readback: request/status, readback stream and ICAP pins.
// The master modport is the readback engine's view; slave is the environment's view.
interface hapara_icap_readback_if;
  logic        start;
  logic [31:0] far;
  logic [26:0] word_cnt;
  logic        busy;
  logic        done;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        icap_csib;
  logic        icap_rdwrb;
  logic [31:0] icap_i;
  logic [31:0] icap_o;

  // Stream: a word moves on every rising edge where m_valid && m_ready; m_data holds while m_valid && !m_ready.
  modport master (
    input  start, far, word_cnt, m_ready, icap_o,
    output busy, done, m_data, m_valid, icap_csib, icap_rdwrb, icap_i
  );

  modport slave (
    output start, far, word_cnt, m_ready, icap_o,
    input  busy, done, m_data, m_valid, icap_csib, icap_rdwrb, icap_i
  );
endinterface

// File: rtl/hapara_icap_readback.sv
// ICAP frame readback engine: command sequence, throttled reads into an output FIFO, desync.
// Optional macro HAPARA_ICAP_READBACK_BITSWAP_EN bit-reverses each byte of icap_i and captured icap_o.
module hapara_icap_readback #(
  parameter int RD_LAT     = 3,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  hapara_icap_readback_if.master bus,
  output logic [2:0]            state_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] THRESH = (CW+1)'(FIFO_DEPTH - RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_SW_RD, S_READ, S_DRAIN, S_SW_WR, S_DESYNC, S_FLUSH
  } state_t;

  state_t            state_q;
  logic [3:0]        idx_q;
  logic [31:0]       far_q;
  logic [26:0]       cnt_q;
  logic [26:0]       rem_q;
  logic              csib_q;
  logic              rdwrb_q;
  logic              busy_q;
  logic              done_q;
  logic [31:0]       icap_wd_q;
  logic [RD_LAT-1:0] pipe_q;
  logic [CW-1:0]     inflight_q;
  logic [CW-1:0]     fifo_cnt_q;
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [31:0]       mem [FIFO_DEPTH];

  logic        issue;
  logic        push;
  logic        pop;
  logic        m_valid_w;
  logic [CW:0] occ_d;
  logic        read_ok;
  logic [31:0] cap_w;

  function automatic logic [31:0] cmd_word(input logic [3:0] i, input logic [31:0] f,
                                           input logic [26:0] n);
    logic [31:0] w;
    case (i)
      4'd0:    w = 32'hFFFF_FFFF;
      4'd1:    w = 32'hAA99_5566;
      4'd3:    w = 32'h3000_2001;
      4'd4:    w = f;
      4'd5:    w = 32'h3000_8001;
      4'd6:    w = 32'h0000_0004;
      4'd8:    w = 32'h2800_6000;
      4'd9:    w = 32'h4800_0000 | {5'd0, n};
      default: w = 32'h2000_0000;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] desync_word(input logic [1:0] i);
    logic [31:0] w;
    case (i)
      2'd0:    w = 32'h3000_8001;
      2'd1:    w = 32'h0000_000D;
      default: w = 32'h2000_0000;
    endcase
    return w;
  endfunction

`ifdef HAPARA_ICAP_READBACK_BITSWAP_EN
  function automatic logic [31:0] byte_rev(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 8; k++)
        r[8*b+k] = w[8*b+7-k];
    return r;
  endfunction
  assign cap_w      = byte_rev(bus.icap_o);
  assign bus.icap_i = byte_rev(icap_wd_q);
`else
  assign cap_w      = bus.icap_o;
  assign bus.icap_i = icap_wd_q;
`endif

  // Only READ ever presents csib=0 with rdwrb=1, so that pin pair alone marks a read.
  assign issue     = !csib_q && rdwrb_q;
  assign push      = pipe_q[RD_LAT-1];
  assign m_valid_w = (fifo_cnt_q != '0);
  assign pop       = m_valid_w && bus.m_ready;
  // Occupancy (buffered + in flight) as it will stand next cycle, so csib can be registered.
  assign occ_d     = (CW+1)'(fifo_cnt_q) + (CW+1)'(inflight_q) + (CW+1)'(issue) - (CW+1)'(pop);
  assign read_ok   = (occ_d <= THRESH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      far_q     <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      csib_q    <= 1'b1;
      rdwrb_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      icap_wd_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start && (bus.word_cnt != '0)) begin
            state_q   <= S_CMD;
            far_q     <= bus.far;
            cnt_q     <= bus.word_cnt;
            rem_q     <= bus.word_cnt;
            idx_q     <= '0;
            csib_q    <= 1'b0;
            busy_q    <= 1'b1;
            icap_wd_q <= 32'hFFFF_FFFF;
          end
        end
        S_CMD: begin
          if (idx_q == 4'd11) begin
            state_q   <= S_SW_RD;
            csib_q    <= 1'b1;
            rdwrb_q   <= 1'b1;
            icap_wd_q <= '0;
          end else begin
            idx_q     <= idx_q + 4'd1;
            icap_wd_q <= cmd_word(idx_q + 4'd1, far_q, cnt_q);
          end
        end
        S_SW_RD: begin
          state_q <= S_READ;
          csib_q  <= !read_ok;
        end
        S_READ: begin
          rem_q <= rem_q - 27'(issue);
          if (issue && (rem_q == 27'd1)) begin
            state_q <= S_DRAIN;
            csib_q  <= 1'b1;
          end else begin
            csib_q  <= !read_ok;
          end
        end
        S_DRAIN: begin
          if (inflight_q == '0) begin
            state_q <= S_SW_WR;
            rdwrb_q <= 1'b0;
          end
        end
        S_SW_WR: begin
          state_q   <= S_DESYNC;
          idx_q     <= '0;
          csib_q    <= 1'b0;
          icap_wd_q <= 32'h3000_8001;
        end
        S_DESYNC: begin
          if (idx_q == 4'd3) begin
            state_q   <= S_FLUSH;
            csib_q    <= 1'b1;
            icap_wd_q <= '0;
          end else begin
            idx_q     <= idx_q + 4'd1;
            icap_wd_q <= desync_word(idx_q[1:0] + 2'd1);
          end
        end
        S_FLUSH: begin
          if (fifo_cnt_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q     <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      pipe_q     <= (pipe_q << 1) | RD_LAT'(issue);
      inflight_q <= inflight_q + CW'(issue) - CW'(push);
      fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= cap_w;
  end

  assign bus.icap_csib  = csib_q;
  assign bus.icap_rdwrb = rdwrb_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.m_valid    = m_valid_w;
  assign bus.m_data     = m_valid_w ? mem[rd_ptr_q] : '0;
  assign state_o        = state_q;
endmodule

// File: tb/tb_hapara_icap_readback.sv
// Self-checking bench for hapara_icap_readback: ICAP responder model, stream scoreboard,
// table-driven operations, randomized operations and directed reset/restart/bitswap sequences.
module tb_hapara_icap_readback;
  localparam int RD_LAT     = 3;
  localparam int FIFO_DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state_o;

  hapara_icap_readback_if bus();

  hapara_icap_readback #(.RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wr_log[$];
  int          due_q[$];
  logic [31:0] due_data_q[$];
  int          cyc = 0;
  int          rd_cnt = 0;
  int          done_cnt = 0;
  int          outstanding = 0;
  int          max_outstanding = 0;
  int          ready_mode = 1;
  logic        force_en = 1'b0;
  logic [31:0] force_word = '0;
  logic [31:0] force_exp = '0;
  logic        prev_rdwrb = 1'b0;

  typedef struct {
    logic [31:0] far;
    logic [26:0] wc;
    int          rmode;
    int          exp_done;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [31:0] bswap(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 8; k++)
        r[8*b+k] = w[8*b+7-k];
    return r;
  endfunction

  function automatic logic [31:0] pin(input logic [31:0] w);
`ifdef HAPARA_ICAP_READBACK_BITSWAP_EN
    return bswap(w);
`else
    return w;
`endif
  endfunction

  // Full ICAP write sequence of one operation: 12 command words then 4 desync words.
  function automatic logic [31:0] exp_write(input int i, input logic [31:0] f, input logic [26:0] n);
    logic [31:0] seq[16];
    seq = '{32'hFFFFFFFF, 32'hAA995566, 32'h20000000, 32'h30002001, f, 32'h30008001,
            32'h00000004, 32'h20000000, 32'h28006000, 32'h48000000 | {5'd0, n},
            32'h20000000, 32'h20000000, 32'h30008001, 32'h0000000D, 32'h20000000,
            32'h20000000};
    return seq[i];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ICAP responder + stream scoreboard, all sampled mid-cycle.
  always @(negedge clk) begin
    logic [31:0] d;
    cyc++;
    case (ready_mode)
      0:       bus.m_ready = 1'b0;
      1:       bus.m_ready = 1'b1;
      default: bus.m_ready = 1'($urandom_range(0, 1));
    endcase
    if (!rst) begin
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", bus.m_data, 32'hDEADDEAD);
        else check("m_data", bus.m_data, exp_q.pop_front());
        outstanding--;
      end
      if (bus.icap_rdwrb !== prev_rdwrb) check("rdwrb_toggle_csib", {31'd0, bus.icap_csib}, 32'd1);
      if (!bus.icap_csib && !bus.icap_rdwrb) wr_log.push_back(bus.icap_i);
      else check("icap_i_zero", bus.icap_i, 32'd0);
      if (!bus.icap_csib && bus.icap_rdwrb) begin
        rd_cnt++;
        outstanding++;
        if (outstanding > max_outstanding) max_outstanding = outstanding;
        d = force_en ? force_word : $urandom;
        due_q.push_back(cyc + RD_LAT);
        due_data_q.push_back(d);
        exp_q.push_back(force_en ? force_exp : pin(d));
      end
      if (bus.done) done_cnt++;
    end
    prev_rdwrb = bus.icap_rdwrb;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      bus.icap_o = due_data_q.pop_front();
      void'(due_q.pop_front());
    end else begin
      bus.icap_o = $urandom;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    rd_cnt = 0;
    done_cnt = 0;
    max_outstanding = outstanding;
  endtask

  task automatic pulse_start(input logic [31:0] f, input logic [26:0] n);
    bus.start    = 1'b1;
    bus.far      = f;
    bus.word_cnt = n;
    tick(1);
    bus.start    = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick(1);
      n++;
    end
    if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_op(input logic [31:0] f, input logic [26:0] n, input int exp_done);
    check("done_count", done_cnt, exp_done);
    check("write_count", wr_log.size(), exp_done ? 32'd16 : 32'd0);
    for (int i = 0; i < wr_log.size() && i < 16; i++)
      check("icap_write", wr_log[i], pin(exp_write(i, f, n)));
    check("reads", rd_cnt, exp_done ? {5'd0, n} : 32'd0);
    check("lost_words", exp_q.size(), 32'd0);
    check("busy_after", {31'd0, bus.busy}, 32'd0);
    check("fifo_bound", {31'd0, max_outstanding > FIFO_DEPTH}, 32'd0);
  endtask

  task automatic run_op(input logic [31:0] f, input logic [26:0] n, input int rmode,
                        input int exp_done);
    clear_logs();
    ready_mode = rmode;
    pulse_start(f, n);
    if (exp_done != 0) begin
      wait_done(3000);
      tick(3);
    end else begin
      tick(40);
    end
    check_op(f, n, exp_done);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    #1;
    check("rst_csib", {31'd0, bus.icap_csib}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    check("rst_m_data", bus.m_data, 32'd0);
    tick(2);
    exp_q.delete();
    due_q.delete();
    due_data_q.delete();
    outstanding = 0;
    rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    int n;
    logic [31:0] f;
    vecs[0] = '{32'h00400000, 27'd5,  1, 1};
    vecs[1] = '{32'h12345678, 27'd1,  2, 1};
    vecs[2] = '{32'h00000000, 27'd0,  1, 0};
    vecs[3] = '{32'hCAFEF00D, 27'd17, 2, 1};
    vecs[4] = '{32'h00A00040, 27'd33, 1, 1};
    vecs[5] = '{32'hFFFFFFFF, 27'd16, 2, 1};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.far = '0;
    bus.word_cnt = '0;
    tick(3);
    check("reset_csib", {31'd0, bus.icap_csib}, 32'd1);
    check("reset_rdwrb", {31'd0, bus.icap_rdwrb}, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_m_valid", {31'd0, bus.m_valid}, 32'd0);
    check("reset_m_data", bus.m_data, 32'd0);
    check("reset_state", {29'd0, state_o}, 32'd0);
    rst = 1'b0;
    tick(2);

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].far, vecs[i].wc, vecs[i].rmode, vecs[i].exp_done);

    // Stream held off: reads must throttle, then everything drains in order.
    clear_logs();
    ready_mode = 0;
    f = $urandom;
    pulse_start(f, 27'd40);
    tick(200);
    check("held_no_done", done_cnt, 32'd0);
    check("held_reads_max", {31'd0, rd_cnt > FIFO_DEPTH - RD_LAT}, 32'd0);
    check("held_reads_min", {31'd0, rd_cnt < FIFO_DEPTH - RD_LAT - 1}, 32'd0);
    check("held_m_valid", {31'd0, bus.m_valid}, 32'd1);
    ready_mode = 1;
    wait_done(3000);
    tick(3);
    check_op(f, 27'd40, 1);

    // Reset during READ after a few reads: abort with no done and no desync.
    clear_logs();
    ready_mode = 0;
    pulse_start(32'h00400000, 27'd20);
    n = 0;
    while (rd_cnt < 3 && n < 200) begin
      tick(1);
      n++;
    end
    check("reads_before_rst", {31'd0, rd_cnt >= 3}, 32'd1);
    reset_pulse();
    tick(30);
    check("abort_no_done", done_cnt, 32'd0);
    check("abort_no_writes", wr_log.size(), 32'd0);
    run_op(32'h00400000, 27'd6, 1, 1);

    // Start while busy is ignored.
    clear_logs();
    ready_mode = 1;
    pulse_start(32'h0000ABCD, 27'd5);
    tick(4);
    pulse_start(32'h55555555, 27'd9);
    wait_done(3000);
    tick(30);
    check_op(32'h0000ABCD, 27'd5, 1);

    // Maximum word count: command word carries all 27 bits, then abort.
    clear_logs();
    ready_mode = 1;
    pulse_start(32'h00000100, 27'h7FFFFFF);
    tick(40);
    check("max_wc_writes", wr_log.size(), 32'd12);
    if (wr_log.size() >= 10) check("max_wc_word", wr_log[9], pin(32'h4FFFFFFF));
    check("max_wc_busy", {31'd0, bus.busy}, 32'd1);
    reset_pulse();

    // Fixed read data to expose the byte bit-reversal path.
    force_en = 1'b1;
    force_word = 32'h01020304;
`ifdef HAPARA_ICAP_READBACK_BITSWAP_EN
    force_exp = 32'h8040C020;
`else
    force_exp = 32'h01020304;
`endif
    run_op(32'h00400000, 27'd2, 1, 1);
    force_en = 1'b0;
    if (wr_log.size() >= 2) begin
`ifdef HAPARA_ICAP_READBACK_BITSWAP_EN
      check("swap_first_word", wr_log[0], 32'hFFFFFFFF);
      check("swap_second_word", wr_log[1], 32'h5599AA66);
`else
      check("first_word", wr_log[0], 32'hFFFFFFFF);
      check("second_word", wr_log[1], 32'hAA995566);
`endif
    end

    for (int i = 0; i < 8; i++)
      run_op($urandom, 27'($urandom_range(1, 48)), $urandom_range(1, 2), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hapara_icap_readback.md
HAPARA_ICAP_READBACK -- requirements
Module: hapara_icap_readback

Interface
REQ-001 SHALL have parameter RD_LAT, default 3: cycles from a read-enabled ICAP cycle to valid icap_o.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: output buffer depth in 32-bit words, power of two, minimum RD_LAT+2.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1: one-cycle readback request, sampled only in IDLE.
REQ-006 SHALL have port far, input, 32: frame address, captured on accepted start.
REQ-007 SHALL have port word_cnt, input, 27: words to read including pad words, captured on accepted start.
REQ-008 SHALL have ports busy (output, 1: high outside IDLE) and done (output, 1: one-cycle completion pulse).
REQ-009 SHALL have ports m_data (output, 32), m_valid (output, 1) and m_ready (input, 1): readback stream, transfer when m_valid&m_ready.
REQ-010 SHALL have ports icap_csib (output, 1: ICAP chip select, active-low), icap_rdwrb (output, 1: 1=read, 0=write), icap_i (output, 32: ICAP write data) and icap_o (input, 32: ICAP read data).

Function
REQ-011 SHALL implement states IDLE, CMD, SW_RD, READ, DRAIN, SW_WR, DESYNC, FLUSH.
REQ-012 SHALL leave IDLE only on start with word_cnt!=0; start with word_cnt=0, or start outside IDLE, SHALL be ignored with no done pulse.
REQ-013 In CMD, SHALL drive icap_csib=0, icap_rdwrb=0 and write one word per cycle, in order: FFFFFFFF, AA995566, 20000000, 30002001, far, 30008001, 00000004, 20000000, 28006000, 48000000|word_cnt, 20000000, 20000000; then go to SW_RD.
REQ-014 SW_RD SHALL last exactly one cycle with icap_csib=1 while icap_rdwrb changes to 1; SW_WR SHALL be the same with icap_rdwrb changing to 0; icap_rdwrb SHALL never change while icap_csib=0.
REQ-015 In READ, SHALL drive icap_csib=0 only when (words in FIFO + words in flight) <= FIFO_DEPTH-RD_LAT-1, otherwise 1.
REQ-016 Each cycle with icap_csib=0 and icap_rdwrb=1 SHALL issue one read; its icap_o SHALL be captured exactly RD_LAT cycles later and pushed to the FIFO; the FIFO SHALL never overflow.
REQ-017 After word_cnt reads are issued, SHALL go to DRAIN; DRAIN SHALL wait until in-flight count is 0, then go to SW_WR.
REQ-018 In DESYNC, SHALL write 30008001, 0000000D, 20000000, 20000000, then go to FLUSH.
REQ-019 FLUSH SHALL wait for FIFO empty, pulse done for one cycle and return to IDLE.
REQ-020 m_data SHALL be the FIFO head, first-in first-out; simultaneous push and pop SHALL be lossless at full and at empty.
REQ-021 m_valid SHALL be high whenever the FIFO is non-empty, independent of state; m_data SHALL hold while m_valid&!m_ready.
REQ-022 The word counter SHALL be 27 bits; word_cnt=07FFFFFF SHALL complete without wrap.
REQ-023 Outside CMD and DESYNC, icap_i SHALL be 00000000.

Reset
REQ-024 On rst high, SHALL at once go to IDLE with FIFO and in-flight pipeline cleared.
REQ-025 On rst high, outputs SHALL be icap_csib=1, icap_rdwrb=0, busy=0, done=0, m_valid=0 and m_data=0.
REQ-026 Reset mid-operation SHALL abort with no done pulse and no DESYNC sequence.

Configuration
REQ-027 With HAPARA_ICAP_READBACK_BITSWAP_EN defined, SHALL bit-reverse each byte of icap_i and of captured icap_o; all words in REQ-013/018 are pre-swap logical values.
REQ-028 Without HAPARA_ICAP_READBACK_BITSWAP_EN, SHALL pass icap_i and icap_o unmodified.

Verification
REQ-029 Scenario: start, far=00400000, word_cnt=5, m_ready=1 -> 12 CMD words exactly as REQ-013, one SW_RD cycle, 5 reads, SW_WR, 4 DESYNC words, 5 words on m_data in order, one done pulse.
REQ-030 Scenario: m_ready=0, word_cnt=40 -> icap_csib rises before 16 words are buffered, no word is lost, all 40 words are delivered in order after m_ready=1.
REQ-031 Scenario: rst pulsed during READ after 3 words -> icap_csib=1, busy=0, m_valid=0 at once, no done pulse; a new start then runs cleanly.
REQ-032 Scenario: start with word_cnt=0, or start while busy -> no ICAP activity, no done pulse, state unaffected.
REQ-033 Scenario: BITSWAP_EN defined, icap_o=01020304 -> m_data=8040C020; first icap_i=FFFFFFFF and second=5599AA66.
REQ-034 Scenario: throughout all tests, checker asserts icap_rdwrb never toggles while icap_csib=0.
